// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 64;
    localparam int WAIT_W      = 4;   // holds MAX_WAIT up to 15
    localparam int NUM_PORTS   = 2;
    localparam int PORT_MA     = 0;
    localparam int PORT_DBG    = 1;

    typedef enum logic [1:0] {
        S_MA_PRI    = 2'd0,
        S_DBG_FORCE = 2'd1,
        S_DBG_LOCK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester (MA, DBG) and data_memory signals around dmem_arbiter.
// slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);
    logic              ma_req, ma_we, ma_gnt, ma_stall, ma_rvalid;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata, ma_rdata;

    logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    modport slave (
        input  ma_req, ma_we, ma_addr, ma_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_rdata,
        output ma_gnt, ma_stall, ma_rvalid, ma_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output ma_req, ma_we, ma_addr, ma_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_rdata,
        input  ma_gnt, ma_stall, ma_rvalid, ma_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/dmem_rsp_reg.sv
// Per-port load response register: captures mem_rdata on a granted load,
// rvalid pulses for the following cycle, rdata holds otherwise.
module dmem_rsp_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cap_i;
            if (cap_i) rdata_q <= mem_rdata_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: MA has fixed priority, DBG is forced
// through after MAX_WAIT lost cycles. Optional DBG lock: DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              ma_gnt, dbg_gnt, dbg_wins, lock_hold;

    logic [NUM_PORTS-1:0]             cap, rvalid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

    // Grant: a lone requester always wins; contention resolved by state.
    always_comb begin
        lock_hold = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock_hold = (state_q == S_DBG_LOCK) && bus.dbg_lock;
`endif
        dbg_wins = bus.dbg_req && (!bus.ma_req || state_q == S_DBG_FORCE || lock_hold);
        dbg_gnt  = !rst && dbg_wins;
        ma_gnt   = !rst && bus.ma_req && !dbg_wins && !lock_hold;
    end

`ifndef DMEM_ARB_LOCK_EN
    logic lock_unused;
    assign lock_unused = bus.dbg_lock;
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
`ifdef DMEM_ARB_LOCK_EN
        if (dbg_gnt && bus.dbg_lock) begin
            state_d    = S_DBG_LOCK;
            wait_cnt_d = '0;
        end else if (state_q == S_DBG_LOCK) begin
            if (!bus.dbg_lock) begin
                state_d    = S_MA_PRI;
                wait_cnt_d = '0;
            end
        end else
`endif
        if (!bus.dbg_req || dbg_gnt) begin
            state_d    = S_MA_PRI;
            wait_cnt_d = '0;
        end else if (ma_gnt) begin
            // DBG lost this cycle; the MAX_WAIT-th consecutive loss forces it next.
            if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q >= WAIT_W'(MAX_WAIT - 1)) state_d = S_DBG_FORCE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_MA_PRI;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // With no grant the bus idles on MA values and never writes.
    assign bus.mem_addr  = dbg_gnt ? bus.dbg_addr  : bus.ma_addr;
    assign bus.mem_wdata = dbg_gnt ? bus.dbg_wdata : bus.ma_wdata;
    assign bus.mem_we    = (ma_gnt & bus.ma_we) | (dbg_gnt & bus.dbg_we);

    assign cap[PORT_MA]  = ma_gnt  & ~bus.ma_we;
    assign cap[PORT_DBG] = dbg_gnt & ~bus.dbg_we;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp (
            .clk        (clk),
            .rst        (rst),
            .cap_i      (cap[p]),
            .mem_rdata_i(bus.mem_rdata),
            .rvalid_o   (rvalid[p]),
            .rdata_o    (rdata[p])
        );
    end

    assign bus.ma_gnt     = ma_gnt;
    assign bus.ma_stall   = bus.ma_req & ~ma_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.ma_rvalid  = rvalid[PORT_MA];
    assign bus.ma_rdata   = rdata[PORT_MA];
    assign bus.dbg_rvalid = rvalid[PORT_DBG];
    assign bus.dbg_rdata  = rdata[PORT_DBG];

endmodule
